// File: rtl/uart_tx_sync.sv
// uart_tx_sync: serial frame transmitter (start, LSB-first data, optional even parity, stop).
// Latency: the start bit appears on tx_serial the cycle after the tx_valid/tx_ready handshake.
//   A frame takes (2+DATA_BITS+PARITY_EN)*CLKS_PER_BIT cycles.
// Backpressure: tx_ready is high only while idle. A word offered while busy waits for the next idle cycle.
//
// Ports:
//   clk       rising-edge system clock
//   rst       synchronous active-high reset; aborts any frame in flight
//   tx_data   word to send, captured at the handshake
//   tx_valid  producer offers tx_data
//   tx_ready  transmitter idle and able to take a word
//   tx_serial serial line, idles high
//   tx_busy   frame in progress
//   tx_done   one-cycle pulse when the stop bit completes
module uart_tx_sync #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_serial,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic [IDX_W-1:0]     r_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_parity;

  logic                 w_handshake;
  logic                 w_bit_end;
  logic                 w_last_data;
  logic [DATA_BITS-1:0] w_shift_nxt;
  logic                 w_serial_nxt;
  logic                 w_ready_nxt;
  logic                 w_done_nxt;

  // tx_ready is a registered copy of "state is IDLE", so it doubles as the idle qualifier.
  assign w_handshake = tx_ready && tx_valid;
  assign w_bit_end   = (r_cnt == CNT_LAST);
  assign w_last_data = (r_idx == IDX_LAST);

  // State register, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_shift   <= '0;
      r_parity  <= 1'b0;
      tx_serial <= 1'b1;
      tx_ready  <= 1'b1;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;

      if (r_state == S_IDLE || w_bit_end) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end

      // Bit index saturates on the final data bit; the state change ends the data phase.
      if (r_state == S_IDLE) begin
        r_idx <= '0;
      end else if (r_state == S_DATA && w_bit_end && !w_last_data) begin
        r_idx <= r_idx + 1'b1;
      end

      if (w_handshake) begin
        r_parity <= ^tx_data;
      end

      tx_serial <= w_serial_nxt;
      tx_ready  <= w_ready_nxt;
      tx_busy   <= !w_ready_nxt;
      tx_done   <= w_done_nxt;
    end
  end

  // Next-state and shift-register update.
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    case (r_state)
      S_IDLE: begin
        if (w_handshake) begin
          w_state_nxt = S_START;
          w_shift_nxt = tx_data;
        end
      end
      S_START: begin
        if (w_bit_end) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_shift_nxt = r_shift >> 1;
          if (w_last_data) w_state_nxt = (PARITY_EN != 0) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (w_bit_end) w_state_nxt = S_STOP;
      end
      S_STOP: begin
        if (w_bit_end) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output values for the coming cycle, derived from the next state so outputs stay registered.
  always_comb begin
    w_serial_nxt = 1'b1;
    case (w_state_nxt)
      S_START:  w_serial_nxt = 1'b0;
      S_DATA:   w_serial_nxt = w_shift_nxt[0];
      S_PARITY: w_serial_nxt = r_parity;
      default:  w_serial_nxt = 1'b1;
    endcase
    w_ready_nxt = (w_state_nxt == S_IDLE);
    w_done_nxt  = (r_state == S_STOP) && w_bit_end;
  end

endmodule

// File: tb/tb_uart_tx_sync.sv
module tb_uart_tx_sync;

  localparam int C = 4;

  logic       clk;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       rdy0, ser0, busy0, done0;
  logic       rdy1, ser1, busy1, done1;

  int total;
  int bad;

  uart_tx_sync #(.DATA_BITS(8), .CLKS_PER_BIT(C), .PARITY_EN(0)) dut0 (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(rdy0), .tx_serial(ser0), .tx_busy(busy0), .tx_done(done0)
  );

  uart_tx_sync #(.DATA_BITS(8), .CLKS_PER_BIT(C), .PARITY_EN(1)) dut1 (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(rdy1), .tx_serial(ser1), .tx_busy(busy1), .tx_done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the frame as a list of line levels, one per bit period.
  function automatic logic exp_bit(input logic [7:0] d, input bit par, input int k);
    logic q[$];
    q.push_back(1'b0);
    for (int i = 0; i < 8; i++) q.push_back(d[i]);
    if (par) q.push_back(^d);
    q.push_back(1'b1);
    return q[k / C];
  endfunction

  task automatic do_reset();
    rst      = 1'b1;
    tx_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Sends d through the selected instance and checks every cycle of the frame.
  // keep_valid: leave tx_valid high and present nd right after the handshake.
  // glitch_k:   offer a different word for one cycle at edge T0+glitch_k (0 = none).
  task automatic run_frame(input logic [7:0] d, input bit par, input bit keep_valid,
                           input logic [7:0] nd, input int glitch_k, input string nm);
    int   f;
    logic s, b, r, dn;
    f = (2 + 8 + (par ? 1 : 0)) * C;
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge clk);
    for (int k = 0; k < f; k++) begin
      @(negedge clk);
      s  = par ? ser1 : ser0;
      b  = par ? busy1 : busy0;
      r  = par ? rdy1 : rdy0;
      dn = par ? done1 : done0;
      total++;
      if ({s, b, r, dn} !== {exp_bit(d, par, k), 3'b100}) begin
        bad++;
        $display("FAIL %s k=%0d ser/busy/rdy/done got=%b%b%b%b want=%b100",
                 nm, k, s, b, r, dn, exp_bit(d, par, k));
      end
      if (k == 0) begin
        if (keep_valid) tx_data = nd;
        else begin
          tx_valid = 1'b0;
          tx_data  = 8'($urandom);
        end
      end
      if (glitch_k > 0 && k == glitch_k - 1) begin
        tx_valid = 1'b1;
        tx_data  = d ^ 8'($urandom_range(1, 255));
      end
      if (glitch_k > 0 && k == glitch_k) tx_valid = 1'b0;
    end
    @(negedge clk);
    s  = par ? ser1 : ser0;
    b  = par ? busy1 : busy0;
    r  = par ? rdy1 : rdy0;
    dn = par ? done1 : done0;
    total++;
    if ({s, b, r, dn} !== 4'b1011) begin
      bad++;
      $display("FAIL %s end ser/busy/rdy/done got=%b%b%b%b want=1011", nm, s, b, r, dn);
    end
    if (!keep_valid) begin
      @(negedge clk);
      s  = par ? ser1 : ser0;
      b  = par ? busy1 : busy0;
      r  = par ? rdy1 : rdy0;
      dn = par ? done1 : done0;
      total++;
      if ({s, b, r, dn} !== 4'b1010) begin
        bad++;
        $display("FAIL %s after ser/busy/rdy/done got=%b%b%b%b want=1010", nm, s, b, r, dn);
      end
    end
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    tx_valid = 1'b1;
    tx_data  = 8'($urandom);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if ({ser0, busy0, rdy0, done0, ser1, busy1, rdy1, done1} !== 8'b1010_1010) begin
        bad++;
        $display("FAIL reset cyc=%0d dut0=%b%b%b%b dut1=%b%b%b%b want=1010 each",
                 i, ser0, busy0, rdy0, done0, ser1, busy1, rdy1, done1);
      end
    end
    rst      = 1'b0;
    tx_valid = 1'b0;
    @(negedge clk);
    total++;
    if ({ser0, busy0, rdy0, done0, ser1, busy1, rdy1, done1} !== 8'b1010_1010) begin
      bad++;
      $display("FAIL reset_release dut0=%b%b%b%b dut1=%b%b%b%b want=1010 each",
               ser0, busy0, rdy0, done0, ser1, busy1, rdy1, done1);
    end
  endtask

  task automatic test_single_frame();
    do_reset();
    run_frame(8'hA5, 1'b0, 1'b0, 8'h00, 0, "single_A5");
  endtask

  task automatic test_parity();
    do_reset();
    run_frame(8'h07, 1'b1, 1'b0, 8'h00, 0, "parity_07");
    do_reset();
    run_frame(8'($urandom), 1'b1, 1'b0, 8'h00, 0, "parity_rand");
  endtask

  task automatic test_back_to_back();
    do_reset();
    run_frame(8'h3C, 1'b0, 1'b1, 8'hFF, 0, "b2b_3C");
    run_frame(8'hFF, 1'b0, 1'b0, 8'h00, 0, "b2b_FF");
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    do_reset();
    d        = 8'($urandom);
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (16) @(negedge clk);
    total++;
    if (ser0 !== exp_bit(d, 1'b0, 16)) begin
      bad++;
      $display("FAIL midrst_pre ser got=%b want=%b", ser0, exp_bit(d, 1'b0, 16));
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if ({ser0, busy0, rdy0, done0} !== 4'b1010) begin
      bad++;
      $display("FAIL midrst_abort ser/busy/rdy/done got=%b%b%b%b want=1010",
               ser0, busy0, rdy0, done0);
    end
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      total++;
      if ({ser0, busy0, rdy0, done0} !== 4'b1010) begin
        bad++;
        $display("FAIL midrst_idle i=%0d ser/busy/rdy/done got=%b%b%b%b want=1010",
                 i, ser0, busy0, rdy0, done0);
      end
    end
    run_frame(8'($urandom), 1'b0, 1'b0, 8'h00, 0, "midrst_new");
  endtask

  task automatic test_busy_ignore();
    do_reset();
    run_frame(8'($urandom), 1'b0, 1'b0, 8'h00, 10, "busy_ignore");
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      do_reset();
      run_frame(8'($urandom), i[0], 1'b0, 8'h00, 0, "random");
    end
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rst      = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    test_reset();
    test_single_frame();
    test_parity();
    test_back_to_back();
    test_reset_mid_frame();
    test_busy_ignore();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
